// File: rtl/bkm_steps_scoreboard.sv
// In-order scoreboard for bkm_steps: queues expected results, converts each
// CSD output beat to binary, compares against the oldest entry with an LSB
// tolerance on X/Y, and reports real-valued results, flags and counters.
module bkm_steps_scoreboard #(
  parameter int unsigned WD          = 72,
  parameter int unsigned WC          = 21,
  parameter int unsigned WFD         = 59,
  parameter int unsigned WFC         = 7,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TOL         = 2,
  parameter int unsigned WCNT        = 16,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     enable,
  input  logic                     exp_valid,
  input  logic [WD-1:0]            exp_X,
  input  logic [WD-1:0]            exp_Y,
  input  logic [WC-1:0]            exp_u,
  input  logic [WC-1:0]            exp_v,
  input  logic                     dut_valid,
  input  logic [2*WD-1:0]          X_out_csd,
  input  logic [2*WD-1:0]          Y_out_csd,
  input  logic [WC-1:0]            u_out_bin,
  input  logic [WC-1:0]            v_out_bin,
  output real                      res_X_out,
  output real                      res_Y_out,
  output real                      res_u_out,
  output real                      res_v_out,
  output logic                     cmp_valid,
  output logic                     cmp_pass,
  output logic [WCNT-1:0]          err_cnt,
  output logic [WCNT-1:0]          cmp_cnt,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     halted
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam bit          STOP    = (STOP_ON_ERR != 0);
  localparam real         SCALE_D = 2.0 ** WFD;
  localparam real         SCALE_C = 2.0 ** WFC;

  typedef struct packed {
    logic [WD-1:0] x;
    logic [WD-1:0] y;
    logic [WC-1:0] u;
    logic [WC-1:0] v;
  } exp_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  // Digit {1,1} is -1, {0,1} is +1; {0,0} and the unused {1,0} count as 0.
  function automatic logic [WD-1:0] csd2bin(input logic [2*WD-1:0] csd);
    logic [WD-1:0] pos;
    logic [WD-1:0] neg;
    for (int i = 0; i < int'(WD); i++) begin
      pos[i] = csd[2*i] & ~csd[2*i+1];
      neg[i] = csd[2*i] &  csd[2*i+1];
    end
    return pos - neg;
  endfunction

  // |a - b| of two signed words, evaluated one bit wider so it cannot wrap.
  function automatic logic [WD:0] abs_diff(input logic [WD-1:0] a, input logic [WD-1:0] b);
    logic signed [WD:0] d;
    d = $signed({a[WD-1], a}) - $signed({b[WD-1], b});
    return d[WD] ? (WD+1)'(-d) : (WD+1)'(d);
  endfunction

  exp_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  state_t          state_q, state_d;

  logic            empty, full;
  logic            push_req, push_fire, push_drop;
  logic            pop_fire, pop_under;
  exp_t            head;
  logic [WD-1:0]   x_bin, y_bin;
  logic [WD:0]     dx, dy;
  logic            pass;

  // Handshake qualification and the combinational compare against the FIFO head.
  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == LW'(DEPTH));
    pop_fire  = enable & dut_valid & (state_q == S_RUN) & ~empty;
    pop_under = enable & dut_valid &
                ((state_q == S_IDLE) | ((state_q == S_RUN) & empty));
    push_req  = enable & exp_valid & (state_q != S_HALT);
    push_fire = push_req & (~full | pop_fire);
    push_drop = push_req & full & ~pop_fire;
    head      = mem[rd_ptr_q];
    x_bin     = csd2bin(X_out_csd);
    y_bin     = csd2bin(Y_out_csd);
    dx        = abs_diff(x_bin, head.x);
    dy        = abs_diff(y_bin, head.y);
    pass      = (dx <= (WD+1)'(TOL)) & (dy <= (WD+1)'(TOL)) &
                (u_out_bin == head.u) & (v_out_bin == head.v);
  end

  // Next-state logic: first push starts the run, a mismatch may halt it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (push_fire) state_d = S_RUN;
      S_RUN:   if (pop_fire && !pass && STOP) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and registered halt indication.
  always_ff @(posedge clk) begin
    if (!srst) begin
      state_q <= S_IDLE;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      halted  <= (state_d == S_HALT);
    end
  end

  // Expected-entry storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (srst && push_fire) mem[wr_ptr_q] <= '{x: exp_X, y: exp_Y, u: exp_u, v: exp_v};
  end

  // FIFO pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (!srst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_fire && !pop_fire)      level_q <= level_q + LW'(1);
      else if (!push_fire && pop_fire) level_q <= level_q - LW'(1);
      if (push_drop) overflow  <= 1'b1;
      if (pop_under) underflow <= 1'b1;
    end
  end

  assign level = level_q;

  // Comparison result pulse, saturating counters and real-valued results.
  always_ff @(posedge clk) begin
    if (!srst) begin
      cmp_valid <= 1'b0;
      cmp_pass  <= 1'b0;
      cmp_cnt   <= '0;
      err_cnt   <= '0;
      res_X_out <= 0.0;
      res_Y_out <= 0.0;
      res_u_out <= 0.0;
      res_v_out <= 0.0;
    end else begin
      cmp_valid <= pop_fire;
      if (pop_fire) begin
        cmp_pass <= pass;
        if (cmp_cnt != '1) cmp_cnt <= cmp_cnt + WCNT'(1);
        if (!pass && err_cnt != '1) err_cnt <= err_cnt + WCNT'(1);
        res_X_out <= real'($signed(x_bin)) / SCALE_D;
        res_Y_out <= real'($signed(y_bin)) / SCALE_D;
        res_u_out <= real'($signed(u_out_bin)) / SCALE_C;
        res_v_out <= real'($signed(v_out_bin)) / SCALE_C;
      end
    end
  end

endmodule

// File: tb/tb_bkm_steps_scoreboard.sv
// Randomized bench for bkm_steps_scoreboard against a queue-based reference.
module tb_bkm_steps_scoreboard;

  localparam int DEPTH = 16;
  localparam int TOL   = 2;

  typedef struct packed {
    logic [71:0] x;
    logic [71:0] y;
    logic [20:0] u;
    logic [20:0] v;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst, srst_h, enable, exp_valid, dut_valid;
  logic [71:0]   exp_X, exp_Y;
  logic [20:0]   exp_u, exp_v, u_out_bin, v_out_bin;
  logic [143:0]  X_out_csd, Y_out_csd;

  real           res_X_out, res_Y_out, res_u_out, res_v_out;
  logic          cmp_valid, cmp_pass, overflow, underflow, halted;
  logic [15:0]   err_cnt, cmp_cnt;
  logic [4:0]    level;

  real           h_res_X_out, h_res_Y_out, h_res_u_out, h_res_v_out;
  logic          h_cmp_valid, h_cmp_pass, h_overflow, h_underflow, h_halted;
  logic [15:0]   h_err_cnt, h_cmp_cnt;
  logic [4:0]    h_level;

  bkm_steps_scoreboard u_dut (
    .clk(clk), .srst(srst), .enable(enable), .exp_valid(exp_valid),
    .exp_X(exp_X), .exp_Y(exp_Y), .exp_u(exp_u), .exp_v(exp_v),
    .dut_valid(dut_valid), .X_out_csd(X_out_csd), .Y_out_csd(Y_out_csd),
    .u_out_bin(u_out_bin), .v_out_bin(v_out_bin),
    .res_X_out(res_X_out), .res_Y_out(res_Y_out), .res_u_out(res_u_out), .res_v_out(res_v_out),
    .cmp_valid(cmp_valid), .cmp_pass(cmp_pass), .err_cnt(err_cnt), .cmp_cnt(cmp_cnt),
    .level(level), .overflow(overflow), .underflow(underflow), .halted(halted)
  );

  bkm_steps_scoreboard #(.STOP_ON_ERR(1)) u_halt (
    .clk(clk), .srst(srst_h), .enable(enable), .exp_valid(exp_valid),
    .exp_X(exp_X), .exp_Y(exp_Y), .exp_u(exp_u), .exp_v(exp_v),
    .dut_valid(dut_valid), .X_out_csd(X_out_csd), .Y_out_csd(Y_out_csd),
    .u_out_bin(u_out_bin), .v_out_bin(v_out_bin),
    .res_X_out(h_res_X_out), .res_Y_out(h_res_Y_out), .res_u_out(h_res_u_out), .res_v_out(h_res_v_out),
    .cmp_valid(h_cmp_valid), .cmp_pass(h_cmp_pass), .err_cnt(h_err_cnt), .cmp_cnt(h_cmp_cnt),
    .level(h_level), .overflow(h_overflow), .underflow(h_underflow), .halted(h_halted)
  );

  int total = 0;
  int bad   = 0;

  // Reference state for the non-halting instance.
  ent_t mq[$];
  bit   m_run, m_ovf, m_und, m_cv, m_cp;
  int   m_cmp, m_err;
  real  m_rx, m_ry, m_ru, m_rv;

  logic [71:0] ex_X, ex_Y;
  logic [20:0] ex_u, ex_v;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_r(input string tag, input real obs, input real expv);
    total++;
    assert (obs == expv) else begin
      bad++;
      $error("FAIL %s observed=%g expected=%g", tag, obs, expv);
    end
  endtask

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // Non-adjacent form: exercises both +1 and -1 digits.
  function automatic logic [143:0] to_naf(input logic [71:0] v);
    logic [73:0]  k;
    logic [143:0] c;
    k = {2'b00, v};
    c = '0;
    for (int i = 0; i < 72; i++) begin
      if (k[0]) begin
        if (k[1]) begin c[2*i +: 2] = 2'b11; k = k + 74'd1; end
        else      begin c[2*i +: 2] = 2'b01; k = k - 74'd1; end
      end
      k = k >> 1;
    end
    return c;
  endfunction

  // Plain binary digits written as CSD (only 0 and +1 digits).
  function automatic logic [143:0] to_plain(input logic [71:0] v);
    logic [143:0] c;
    c = '0;
    for (int i = 0; i < 72; i++) c[2*i] = v[i];
    return c;
  endfunction

  function automatic real to_real_d(input logic [71:0] v);
    return real'(longint'(v[63:0])) / (2.0 ** 59);
  endfunction

  function automatic real to_real_c(input logic [20:0] v);
    return real'(int'($signed(v))) / 128.0;
  endfunction

  task automatic rnd_exp();
    longint r;
    r = longint'({$urandom(), $urandom()}) >>> 16;
    ex_X = 72'(r);
    r = longint'({$urandom(), $urandom()}) >>> 16;
    ex_Y = 72'(r);
    ex_u = 21'($urandom());
    ex_v = 21'($urandom());
  endtask

  task automatic check_a();
    chk("cmp_valid", cmp_valid, m_cv);
    chk("cmp_pass",  cmp_pass,  m_cp);
    chk("level",     level,     mq.size());
    chk("cmp_cnt",   cmp_cnt,   m_cmp);
    chk("err_cnt",   err_cnt,   m_err);
    chk("overflow",  overflow,  m_ovf);
    chk("underflow", underflow, m_und);
    chk("halted",    halted,    1'b0);
    chk_r("res_X", res_X_out, m_rx);
    chk_r("res_Y", res_Y_out, m_ry);
    chk_r("res_u", res_u_out, m_ru);
    chk_r("res_v", res_v_out, m_rv);
  endtask

  // One clock: drive push of ex_*, a beat derived from the oldest expected
  // entry plus the given offsets, then update the reference and check.
  task automatic step(input bit en, input bit pv, input bit dv,
                      input int dx, input int dy, input int du, input int dvv);
    ent_t        b;
    logic [71:0] xv, yv;
    logic [20:0] uv, vv;
    bit          popok, pass;
    enable = en; exp_valid = pv; dut_valid = dv;
    exp_X = ex_X; exp_Y = ex_Y; exp_u = ex_u; exp_v = ex_v;
    if (mq.size() > 0) b = mq[0];
    else b = '{x: ex_X, y: ex_Y, u: ex_u, v: ex_v};
    xv = b.x + 72'(dx);
    yv = b.y + 72'(dy);
    uv = b.u + 21'(du);
    vv = b.v + 21'(dvv);
    if ($urandom_range(1) == 0) begin
      X_out_csd = to_naf(xv);   Y_out_csd = to_naf(yv);
    end else begin
      X_out_csd = to_plain(xv); Y_out_csd = to_plain(yv);
    end
    u_out_bin = uv; v_out_bin = vv;
    @(posedge clk);
    if (en) begin
      popok = dv && m_run && (mq.size() > 0);
      if (dv && !popok) m_und = 1'b1;
      m_cv = popok;
      if (popok) begin
        void'(mq.pop_front());
        pass = (iabs(dx) <= TOL) && (iabs(dy) <= TOL) && (du == 0) && (dvv == 0);
        m_cp = pass;
        if (m_cmp < 65535) m_cmp++;
        if (!pass && m_err < 65535) m_err++;
        m_rx = to_real_d(xv); m_ry = to_real_d(yv);
        m_ru = to_real_c(uv); m_rv = to_real_c(vv);
      end
      if (pv) begin
        if (mq.size() >= DEPTH) m_ovf = 1'b1;
        else begin
          mq.push_back('{x: ex_X, y: ex_Y, u: ex_u, v: ex_v});
          m_run = 1'b1;
        end
      end
    end else begin
      m_cv = 1'b0;
    end
    #1;
    check_a();
  endtask

  // Reset with every request active, to show reset wins.
  task automatic reset_a();
    srst = 1'b0; enable = 1'b1; exp_valid = 1'b1; dut_valid = 1'b1;
    @(posedge clk);
    mq.delete();
    m_run = 0; m_ovf = 0; m_und = 0; m_cv = 0; m_cp = 0;
    m_cmp = 0; m_err = 0;
    m_rx = 0.0; m_ry = 0.0; m_ru = 0.0; m_rv = 0.0;
    #1;
    check_a();
    srst = 1'b1;
  endtask

  function automatic int rdelta();
    return ($urandom_range(3) == 0) ? int'($urandom_range(6)) - 3 : 0;
  endfunction

  initial begin
    int  save_cmp;
    real hold_rx, hold_ru;
    srst = 1'b0; srst_h = 1'b0; enable = 1'b0; exp_valid = 1'b0; dut_valid = 1'b0;
    exp_X = '0; exp_Y = '0; exp_u = '0; exp_v = '0;
    X_out_csd = '0; Y_out_csd = '0; u_out_bin = '0; v_out_bin = '0;
    rnd_exp();
    reset_a();
    chk("h_reset_level",  h_level,     5'd0);
    chk("h_reset_halted", h_halted,    1'b0);
    chk("h_reset_cv",     h_cmp_valid, 1'b0);

    // Basic push then matching beat.
    ex_X = 72'h10; ex_Y = '0; ex_u = 21'd3; ex_v = 21'd3;
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("t1_cv", cmp_valid, 1'b1);
    chk("t1_pass", cmp_pass, 1'b1);
    chk("t1_cmp_cnt", cmp_cnt, 16'd1);
    chk("t1_err_cnt", err_cnt, 16'd0);
    chk_r("t1_res_u", res_u_out, 0.0234375);
    chk_r("t1_res_X", res_X_out, 16.0 / (2.0 ** 59));

    // Tolerance edge: +2 passes, +3 fails, u off by one fails.
    rnd_exp(); step(1, 1, 0, 0, 0, 0, 0);
    rnd_exp(); step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 2, -2, 0, 0);
    chk("t2_pass_tol", cmp_pass, 1'b1);
    step(1, 0, 1, 3, 0, 0, 0);
    chk("t2_fail_tol", cmp_pass, 1'b0);
    chk("t2_err1", err_cnt, 16'd1);
    rnd_exp(); step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    chk("t2_fail_u", cmp_pass, 1'b0);
    chk("t2_err2", err_cnt, 16'd2);
    chk("t2_cmp4", cmp_cnt, 16'd4);

    // Overflow, then push+pop while full.
    for (int i = 0; i < DEPTH + 1; i++) begin rnd_exp(); step(1, 1, 0, 0, 0, 0, 0); end
    chk("t3_level_full", level, 5'd16);
    chk("t3_overflow", overflow, 1'b1);
    rnd_exp(); step(1, 1, 1, 0, 0, 0, 0);
    chk("t3_level_keep", level, 5'd16);
    chk("t3_pass", cmp_pass, 1'b1);
    while (mq.size() > 0) step(1, 0, 1, rdelta(), rdelta(), 0, 0);

    // Beat on empty FIFO with a simultaneous push.
    rnd_exp(); step(1, 1, 1, 0, 0, 0, 0);
    chk("t4_underflow", underflow, 1'b1);
    chk("t4_no_cv", cmp_valid, 1'b0);
    chk("t4_level", level, 5'd1);
    step(1, 0, 1, 0, 0, 0, 0);

    // enable low freezes everything.
    rnd_exp(); step(1, 1, 0, 0, 0, 0, 0);
    rnd_exp(); step(1, 1, 0, 0, 0, 0, 0);
    save_cmp = m_cmp;
    rnd_exp(); step(0, 1, 1, 0, 0, 0, 0);
    rnd_exp(); step(0, 1, 1, 0, 0, 0, 0);
    chk("t6_level", level, 5'd2);
    chk("t6_no_cv", cmp_valid, 1'b0);
    chk("t6_cmp_cnt", cmp_cnt, 16'(save_cmp));
    step(1, 0, 1, 0, 0, 0, 0);
    chk("t6_resume_cv", cmp_valid, 1'b1);
    step(1, 0, 1, 0, 0, 0, 0);

    // Random traffic with a mid-stream reset.
    for (int i = 0; i < 160; i++) begin
      if (i == 80) reset_a();
      rnd_exp();
      step($urandom_range(9) != 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
           rdelta(), rdelta(), ($urandom_range(7) == 0) ? 1 : 0, 0);
    end
    while (mq.size() > 0) step(1, 0, 1, 0, 0, 0, 0);

    // Halt-on-error instance, now in lockstep with an empty reference queue.
    srst_h = 1'b1;
    rnd_exp(); step(1, 1, 0, 0, 0, 0, 0);
    chk("t5_level1", h_level, 5'd1);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("t5_pass", h_cmp_pass, 1'b1);
    chk("t5_not_halted", h_halted, 1'b0);
    rnd_exp(); step(1, 1, 0, 0, 0, 0, 0);
    rnd_exp(); step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 3, 0, 0, 0);
    chk("t5_fail_cv", h_cmp_valid, 1'b1);
    chk("t5_fail_pass", h_cmp_pass, 1'b0);
    chk("t5_halted", h_halted, 1'b1);
    chk("t5_err", h_err_cnt, 16'd1);
    hold_rx = m_rx; hold_ru = m_ru;
    rnd_exp(); step(1, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("t5_frozen_level", h_level, 5'd1);
    chk("t5_frozen_cv", h_cmp_valid, 1'b0);
    chk("t5_frozen_cnt", h_cmp_cnt, 16'd2);
    chk("t5_still_halted", h_halted, 1'b1);
    chk("t5_no_underflow", h_underflow, 1'b0);
    chk_r("t5_hold_X", h_res_X_out, hold_rx);
    chk_r("t5_hold_u", h_res_u_out, hold_ru);
    srst_h = 1'b0;
    rnd_exp(); step(1, 1, 1, 0, 0, 0, 0);
    chk("t5_rst_level", h_level, 5'd0);
    chk("t5_rst_halted", h_halted, 1'b0);
    chk("t5_rst_cnt", h_cmp_cnt, 16'd0);
    chk("t5_rst_err", h_err_cnt, 16'd0);
    chk("t5_rst_pass", h_cmp_pass, 1'b0);
    chk_r("t5_rst_X", h_res_X_out, 0.0);
    while (mq.size() > 0) step(1, 0, 1, 0, 0, 0, 0);
    srst_h = 1'b1;
    rnd_exp(); step(1, 1, 0, 0, 0, 0, 0);
    chk("t5_idle_push", h_level, 5'd1);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("t5_rerun_cv", h_cmp_valid, 1'b1);
    chk("t5_rerun_pass", h_cmp_pass, 1'b1);
    chk("t5_rerun_halted", h_halted, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
